// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: FSM states, access sizes,
// byte-enable constants and store-data lane replication.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } memSize_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    function automatic logic [3:0] byteEnable(input memSize_t size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 4'b0001 << addr;
            SZ_HALF: return addr[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input memSize_t size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment: selects the byte/half lane from a 32-bit read word and
// sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  memSize_t    size,
    input  logic        isUnsigned,
    output logic [31:0] value
);

    logic [7:0]  laneByte [4];
    logic [15:0] laneHalf;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign laneByte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign laneHalf = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (size)
            SZ_BYTE: value = {{24{~isUnsigned & laneByte[addr][7]}}, laneByte[addr]};
            SZ_HALF: value = {{16{~isUnsigned & laneHalf[15]}}, laneHalf};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: req/ack data-memory transaction,
// load alignment and the MEM/WB register. Define MEM_ALIGN_CHECK_EN to trap
// misaligned half/word accesses instead of forcing them aligned.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus8M,
    input  logic [4:0]  WriteRegM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    input  logic        LinkM,
    input  logic        IsLbSbM,
    input  logic        IsLhShM,
    input  logic        IsUnsignedM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic [31:0] ResultW,
    output logic [4:0]  WriteRegW,
    output logic        RegWriteW,
    output logic        AddrErrM
);

    logic        memOp;
    logic        busOp;
    logic        misaligned;
    memSize_t    accSize;
    memState_t   stateReg, stateNext;
    logic [31:0] loadBufReg;
    logic [31:0] loadValue;
    logic [31:0] resultNext;

    assign memOp   = MemWriteM | MemToRegM;
    assign accSize = IsLbSbM ? SZ_BYTE : (IsLhShM ? SZ_HALF : SZ_WORD);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memOp & (((accSize == SZ_HALF) & ALUOutM[0]) |
                                 ((accSize == SZ_WORD) & (ALUOutM[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            AddrErrM <= 1'b0;
        end else begin
            AddrErrM <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign AddrErrM   = 1'b0;
`endif

    // A trapped access never touches the bus, so it also never stalls.
    assign busOp  = memOp & ~misaligned;
    assign StallM = busOp & (stateReg != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (busOp) stateNext = BUSY;
            BUSY:    if (dmem_ack) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            loadBufReg <= 32'h0;
        end else begin
            if ((stateReg == IDLE) && busOp) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteM;
                dmem_addr  <= {ALUOutM[31:2], 2'b00};
                dmem_be    <= byteEnable(accSize, ALUOutM[1:0]);
                dmem_wdata <= storeData(accSize, WriteDataM);
            end
            if ((stateReg == BUSY) && dmem_ack) begin
                dmem_req   <= 1'b0;
                loadBufReg <= dmem_rdata;
            end
        end
    end

    mem_load_ext u_loadExt (
        .rdata      (loadBufReg),
        .addr       (ALUOutM[1:0]),
        .size       (accSize),
        .isUnsigned (IsUnsignedM),
        .value      (loadValue)
    );

    assign resultNext = LinkM ? PCPlus8M : (MemToRegM ? loadValue : ALUOutM);

    always_ff @(posedge clk) begin
        if (rst) begin
            ResultW   <= 32'h0;
            WriteRegW <= 5'd0;
            RegWriteW <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM & ~misaligned;
            ResultW   <= resultNext;
            WriteRegW <= WriteRegM;
        end
    end

endmodule
